// File: rtl/sim_run_ctrl.sv
// Test-run sequencer: stretches the core reset, supervises the run with a cycle limit and a
// retirement watchdog, drains after halt and latches a terminal pass/fail verdict with cause.
module sim_run_ctrl #(
  parameter int unsigned HOLD_CYCLES  = 5,
  parameter int unsigned TIMEOUT      = 100000,
  parameter int unsigned WDOG_CYCLES  = 1000,
  parameter int unsigned DRAIN_CYCLES = 4,
  parameter int unsigned CNT_W        = 32
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_halt_req,
  input  logic             i_halt_code,
  input  logic             i_retire,
  output logic             o_core_rst,
  output logic             o_running,
  output logic             o_done,
  output logic             o_pass,
  output logic [1:0]       o_cause,
  output logic [CNT_W-1:0] o_cycle_count,
  output logic [CNT_W-1:0] o_retire_count
);

  typedef enum logic [1:0] {StHold, StRun, StDrain, StDone} state_e;

  localparam logic [1:0] CauseNone  = 2'b00;
  localparam logic [1:0] CauseHalt  = 2'b01;
  localparam logic [1:0] CauseTmo   = 2'b10;
  localparam logic [1:0] CauseWdog  = 2'b11;

  localparam logic [31:0]      HoldLast    = 32'(HOLD_CYCLES - 1);
  localparam logic [31:0]      WdogLast    = 32'(WDOG_CYCLES - 1);
  // Unused when DRAIN_CYCLES is zero; the halt path then bypasses DRAIN entirely.
  localparam logic [31:0]      DrainLast   = 32'(DRAIN_CYCLES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT - 1);
  localparam bit               NoDrain     = (DRAIN_CYCLES == 0);

  state_e           r_state;
  logic [31:0]      r_hold_cnt;
  logic [31:0]      r_wdog_cnt;
  logic [31:0]      r_drain_cnt;
  logic             r_core_rst;
  logic             r_running;
  logic             r_done;
  logic             r_pass;
  logic [1:0]       r_cause;
  logic [CNT_W-1:0] r_cycle_count;
  logic [CNT_W-1:0] r_retire_count;

  logic [CNT_W-1:0] w_cycle_inc;
  logic [CNT_W-1:0] w_retire_inc;
  logic [31:0]      w_wdog_inc;

  // Saturating increments: counters stick at all-ones rather than wrapping.
  assign w_cycle_inc  = (&r_cycle_count)  ? r_cycle_count  : r_cycle_count + 1'b1;
  assign w_retire_inc = (&r_retire_count) ? r_retire_count : r_retire_count + 1'b1;
  assign w_wdog_inc   = (&r_wdog_cnt)     ? r_wdog_cnt     : r_wdog_cnt + 1'b1;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state        <= StHold;
      r_hold_cnt     <= '0;
      r_wdog_cnt     <= '0;
      r_drain_cnt    <= '0;
      r_core_rst     <= 1'b1;
      r_running      <= 1'b0;
      r_done         <= 1'b0;
      r_pass         <= 1'b0;
      r_cause        <= CauseNone;
      r_cycle_count  <= '0;
      r_retire_count <= '0;
    end else begin
      unique case (r_state)
        StHold: begin
          r_hold_cnt <= r_hold_cnt + 1'b1;
          if (r_hold_cnt == HoldLast) begin
            r_state    <= StRun;
            r_core_rst <= 1'b0;
            r_running  <= 1'b1;
          end
        end

        StRun: begin
          r_cycle_count <= w_cycle_inc;
          if (i_retire) begin
            r_retire_count <= w_retire_inc;
            r_wdog_cnt     <= '0;
          end else begin
            r_wdog_cnt <= w_wdog_inc;
          end
          // Exit priority: halt, then timeout, then watchdog.
          if (i_halt_req) begin
            r_running   <= 1'b0;
            r_pass      <= i_halt_code;
            r_cause     <= CauseHalt;
            r_drain_cnt <= '0;
            if (NoDrain) begin
              r_state    <= StDone;
              r_done     <= 1'b1;
              r_core_rst <= 1'b1;
            end else begin
              r_state <= StDrain;
            end
          end else if (r_cycle_count == TimeoutLast) begin
            r_state    <= StDone;
            r_running  <= 1'b0;
            r_done     <= 1'b1;
            r_core_rst <= 1'b1;
            r_pass     <= 1'b0;
            r_cause    <= CauseTmo;
          end else if (!i_retire && r_wdog_cnt == WdogLast) begin
            r_state    <= StDone;
            r_running  <= 1'b0;
            r_done     <= 1'b1;
            r_core_rst <= 1'b1;
            r_pass     <= 1'b0;
            r_cause    <= CauseWdog;
          end
        end

        StDrain: begin
          if (i_retire) begin
            r_retire_count <= w_retire_inc;
          end
          if (r_drain_cnt == DrainLast) begin
            r_state    <= StDone;
            r_done     <= 1'b1;
            r_core_rst <= 1'b1;
          end else begin
            r_drain_cnt <= r_drain_cnt + 1'b1;
          end
        end

        StDone: begin
        end

        default: r_state <= StHold;
      endcase
    end
  end

  assign o_core_rst     = r_core_rst;
  assign o_running      = r_running;
  assign o_done         = r_done;
  assign o_pass         = r_pass;
  assign o_cause        = r_cause;
  assign o_cycle_count  = r_cycle_count;
  assign o_retire_count = r_retire_count;

endmodule

// File: tb/tb_sim_run_ctrl.sv
// Bench for sim_run_ctrl: directed scenarios push expected verdicts into a queue; a monitor
// pops and compares each time the controller raises done.
module tb_sim_run_ctrl;

  localparam int unsigned CntW = 32;

  logic            clk;
  logic            rst;
  logic            halt_req;
  logic            halt_code;
  logic            retire;
  logic            core_rst;
  logic            running;
  logic            done;
  logic            pass;
  logic [1:0]      cause;
  logic [CntW-1:0] cycle_count;
  logic [CntW-1:0] retire_count;

  sim_run_ctrl #(
    .HOLD_CYCLES (5),
    .TIMEOUT     (20),
    .WDOG_CYCLES (6),
    .DRAIN_CYCLES(4),
    .CNT_W       (CntW)
  ) u_dut (
    .i_clk         (clk),
    .i_rst         (rst),
    .i_halt_req    (halt_req),
    .i_halt_code   (halt_code),
    .i_retire      (retire),
    .o_core_rst    (core_rst),
    .o_running     (running),
    .o_done        (done),
    .o_pass        (pass),
    .o_cause       (cause),
    .o_cycle_count (cycle_count),
    .o_retire_count(retire_count)
  );

  typedef struct {
    string       tag;
    logic        pass;
    logic [1:0]  cause;
    logic [31:0] cyc;
    logic [31:0] ret;
  } verdict_t;

  verdict_t exp_q[$];
  int       n_cmp = 0;
  int       n_err = 0;
  logic     done_seen = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: one verdict per rising done, sampled on the falling clock edge.
  always @(negedge clk) begin
    if (done !== 1'b1) begin
      done_seen = 1'b0;
    end else if (!done_seen) begin
      verdict_t v;
      done_seen = 1'b1;
      if (exp_q.size() == 0) begin
        check("unexpected done", 32'(done), 32'd0);
      end else begin
        v = exp_q.pop_front();
        check({v.tag, " pass"},     32'(pass),     32'(v.pass));
        check({v.tag, " cause"},    32'(cause),    32'(v.cause));
        check({v.tag, " cycles"},   cycle_count,   v.cyc);
        check({v.tag, " retires"},  retire_count,  v.ret);
        check({v.tag, " core_rst"}, 32'(core_rst), 32'd1);
        check({v.tag, " running"},  32'(running),  32'd0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_verdict(input string tag, input logic p, input logic [1:0] c,
                                input logic [31:0] cy, input logic [31:0] rt);
    verdict_t v;
    v.tag = tag; v.pass = p; v.cause = c; v.cyc = cy; v.ret = rt;
    exp_q.push_back(v);
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, " core_rst"}, 32'(core_rst), 32'd1);
    check({tag, " running"},  32'(running),  32'd0);
    check({tag, " done"},     32'(done),     32'd0);
    check({tag, " pass"},     32'(pass),     32'd0);
    check({tag, " cause"},    32'(cause),    32'd0);
    check({tag, " cycles"},   cycle_count,   32'd0);
    check({tag, " retires"},  retire_count,  32'd0);
  endtask

  task automatic do_reset(input int n);
    rst = 1'b1; halt_req = 1'b0; halt_code = 1'b0; retire = 1'b0;
    repeat (n) tick();
    rst = 1'b0;
  endtask

  // core_rst stays high for four edges after release and drops on the fifth.
  task automatic release_hold(input string tag);
    repeat (4) tick();
    check({tag, " hold core_rst"}, 32'(core_rst), 32'd1);
    check({tag, " hold running"},  32'(running),  32'd0);
    tick();
    check({tag, " run core_rst"}, 32'(core_rst), 32'd0);
    check({tag, " run running"},  32'(running),  32'd1);
    check({tag, " run done"},     32'(done),     32'd0);
    check({tag, " run cycles"},   cycle_count,   32'd0);
  endtask

  task automatic run_halt_pass(input string tag);
    retire = 1'b1;
    repeat (9) tick();
    halt_req = 1'b1; halt_code = 1'b1;
    expect_verdict(tag, 1'b1, 2'b01, 32'd10, 32'd14);
    tick();
    halt_req = 1'b0; halt_code = 1'b0;
    check({tag, " drain running"}, 32'(running),  32'd0);
    check({tag, " drain cause"},   32'(cause),    32'd1);
    check({tag, " drain pass"},    32'(pass),     32'd1);
    check({tag, " drain core_rst"}, 32'(core_rst), 32'd0);
    repeat (3) tick();
    check({tag, " drain done"},   32'(done),   32'd0);
    check({tag, " drain cycles"}, cycle_count, 32'd10);
    tick();
    retire = 1'b0;
    check({tag, " final done"}, 32'(done), 32'd1);
    tick();
  endtask

  initial begin
    rst = 1'b1; halt_req = 1'b0; halt_code = 1'b0; retire = 1'b0;

    // 1: hold release
    do_reset(3);
    check_reset_state("reset");
    release_hold("s1");

    // 2: halt with pass verdict
    run_halt_pass("s2");

    // 3: timeout, then DONE ignores all inputs
    do_reset(2);
    release_hold("s3");
    retire = 1'b1;
    expect_verdict("s3 timeout", 1'b0, 2'b10, 32'd20, 32'd20);
    repeat (19) tick();
    check("s3 before timeout done", 32'(done), 32'd0);
    tick();
    halt_req = 1'b1; halt_code = 1'b1;
    repeat (3) tick();
    halt_req = 1'b0; retire = 1'b0;
    check("s3 frozen cause",   32'(cause),   32'd2);
    check("s3 frozen pass",    32'(pass),    32'd0);
    check("s3 frozen retires", retire_count, 32'd20);
    check("s3 frozen cycles",  cycle_count,  32'd20);

    // 4: watchdog, no retire at all
    do_reset(2);
    release_hold("s4");
    expect_verdict("s4 watchdog", 1'b0, 2'b11, 32'd6, 32'd0);
    repeat (5) tick();
    check("s4 before wdog done", 32'(done), 32'd0);
    tick();
    tick();

    // 4b: retire every fifth cycle keeps the watchdog quiet; timeout wins
    do_reset(2);
    release_hold("s4b");
    expect_verdict("s4b timeout", 1'b0, 2'b10, 32'd20, 32'd4);
    for (int k = 1; k <= 20; k++) begin
      retire = (k % 5 == 0);
      tick();
    end
    retire = 1'b0;
    tick();

    // 5: halt (fail) coincides with timeout; halt during DRAIN is ignored
    do_reset(2);
    release_hold("s5");
    retire = 1'b1;
    repeat (19) tick();
    halt_req = 1'b1; halt_code = 1'b0;
    expect_verdict("s5 halt", 1'b0, 2'b01, 32'd20, 32'd24);
    tick();
    halt_code = 1'b1;
    check("s5 drain cause",   32'(cause),   32'd1);
    check("s5 drain pass",    32'(pass),    32'd0);
    check("s5 drain done",    32'(done),    32'd0);
    check("s5 drain running", 32'(running), 32'd0);
    repeat (4) tick();
    halt_req = 1'b0; halt_code = 1'b0; retire = 1'b0;
    tick();

    // 6: reset during DRAIN, then a clean rerun
    do_reset(2);
    release_hold("s6");
    retire = 1'b1;
    repeat (3) tick();
    halt_req = 1'b1; halt_code = 1'b1;
    tick();
    halt_req = 1'b0;
    tick();
    rst = 1'b1; retire = 1'b0;
    tick();
    check_reset_state("s6 midreset");
    rst = 1'b0;
    release_hold("s6 rerun");
    run_halt_pass("s6 rerun");

    repeat (2) tick();
    check("pending verdicts", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
